muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: MULDIV_UNIT

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_step.sv | 24 ++
 rtl/muldiv_unit.sv | 89 ++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and defaults for the HI/LO multiply/divide unit
package muldiv_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    typedef enum logic {MODE_MUL, MODE_DIV} mode_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step import muldiv_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  mode_t             mode,
    input  logic [WIDTH-1:0]  acc,
    input  logic [WIDTH-1:0]  low,
    input  logic [WIDTH-1:0]  operand,
    output logic [WIDTH-1:0]  acc_next,
    output logic [WIDTH-1:0]  low_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, low[0] ? operand : {WIDTH{1'b0}}};
        shifted  = {acc, low[WIDTH-1]};
        fits     = shifted >= {1'b0, operand};
        diff     = shifted[WIDTH-1:0] - operand;
        acc_next = mode == MODE_DIV ? (fits ? diff : shifted[WIDTH-1:0]) : sum[WIDTH:1];
        low_next = mode == MODE_DIV ? {low[WIDTH-2:0], fits} : {sum[0], low[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style MULT/DIV with HI/LO registers and MTHI/MTLO moves
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t             state, state_n;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc, low, operand, acc_next, low_next, mag_a, mag_b;
    logic [2*WIDTH-1:0] product;
    logic               sign_a, sign_b, res_neg, rem_neg, div_op;
    muldiv_step #(.WIDTH(WIDTH)) step (
        .mode(state == DIV ? MODE_DIV : MODE_MUL),
        .acc(acc),
        .low(low),
        .operand(operand),
        .acc_next(acc_next),
        .low_next(low_next)
    );
    assign busy = state != IDLE;
    always_comb begin
        sign_a  = op[0] && opA[WIDTH-1];
        sign_b  = op[0] && opB[WIDTH-1];
        mag_a   = sign_a ? -opA : opA;
        mag_b   = sign_b ? -opB : opB;
        product = res_neg ? -{acc, low} : {acc, low};
        state_n = state;
        case (state)
            IDLE:     state_n = !start ? IDLE
                              : (op == OP_MULTU || op == OP_MULT) ? MUL
                              : (op == OP_DIVU || op == OP_DIV) ? DIV : IDLE;
            MUL, DIV: state_n = count == CW'(WIDTH - 1) ? FIX : state;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) state <= reset ? IDLE : state_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            acc     <= '0;
            low     <= '0;
            operand <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            div_op  <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: if (start) begin
                    if (op == OP_MTHI) hi <= opA;
                    if (op == OP_MTLO) lo <= opA;
                    // magnitudes are iterated unsigned; signs are re-applied in FIX
                    if (state_n != IDLE) begin
                        count   <= '0;
                        acc     <= '0;
                        low     <= mag_a;
                        operand <= mag_b;
                        res_neg <= sign_a ^ sign_b;
                        rem_neg <= sign_a;
                        div_op  <= state_n == DIV;
                    end
                end
                MUL, DIV: begin
                    acc   <= acc_next;
                    low   <= low_next;
                    count <= count + CW'(1);
                end
                default: begin
                    // divide-by-zero leaves |opA| in acc, so the remainder rule restores opA
                    hi <= div_op ? (rem_neg ? -acc : acc) : product[2*WIDTH-1:WIDTH];
                    lo <= div_op ? (operand == '0 ? '1 : res_neg ? -low : low) : product[WIDTH-1:0];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32
module tb_muldiv_unit;
    import muldiv_pkg::*;
    logic        clock = 0, reset = 1, start = 0;
    logic [2:0]  op = 0;
    logic [31:0] opA = 0, opB = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          total = 0, bad = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] sa, sbv, q, r;
        sa = a;
        sbv = b;
        case (o)
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            OP_DIVU: return b == 0 ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = sa / sbv;
                r = sa % sbv;
                return {r, q};
            end
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        int cyc;
        bit busy_ok, hold_ok;
        logic [63:0] prev, exp;
        prev = {hi, lo};
        start = 1; op = o; opA = a; opB = b;
        sb.push_back(model(o, a, b));
        @(negedge clock);
        start = 0;
        cyc = 1; busy_ok = 1; hold_ok = 1;
        while (!done && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 0;
            if ({hi, lo} !== prev) hold_ok = 0;
            @(negedge clock);
            cyc++;
        end
        total++; if (cyc !== 34) begin bad++; $display("FAIL %s done_cycle: got %0d want 34", name, cyc); end
        total++; if (!busy_ok) begin bad++; $display("FAIL %s busy_window: busy dropped before done, want 1 in cycles 1..33", name); end
        total++; if (!hold_ok) begin bad++; $display("FAIL %s hilo_hold: hi/lo changed before done, want %h", name, prev); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
        exp = sb.pop_front();
        total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]); end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        reset = 0;
    endtask

    task automatic test_moves();
        start = 1; op = OP_MTHI; opA = 32'h12345678;
        @(negedge clock);
        start = 0;
        total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
        @(negedge clock);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_flags2: got busy=%b done=%b want 0 0", busy, done); end
        start = 1; op = OP_MTLO; opA = 32'h9ABCDEF0;
        @(negedge clock);
        start = 0;
        total++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin bad++; $display("FAIL mtlo_hilo: got %h want 123456789abcdef0", {hi, lo}); end
    endtask

    task automatic test_reserved();
        logic [63:0] prev;
        for (int k = 6; k < 8; k++) begin
            prev = {hi, lo};
            start = 1; op = 3'(k); opA = 32'hCAFEF00D; opB = 32'h3;
            @(negedge clock);
            start = 0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reserved%0d_busy: got %b want 0", k, busy); end
            @(negedge clock);
            total++; if (done !== 1'b0 || {hi, lo} !== prev) begin bad++; $display("FAIL reserved%0d_state: got done=%b hilo=%h want 0 %h", k, done, {hi, lo}, prev); end
        end
    endtask

    task automatic test_vectors();
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
        total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_max_const: got %h want fffffffe00000001", {hi, lo}); end
        do_op(OP_MULT, 32'hFFFFFFFD, 32'h00000005, "mult_neg");
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin bad++; $display("FAIL mult_neg_const: got %h want fffffffffffffff1", {hi, lo}); end
        do_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, "div_neg");
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_neg_const: got %h want fffffffffffffffd", {hi, lo}); end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        total++; if ({hi, lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_ovf_const: got %h want 0000000080000000", {hi, lo}); end
        do_op(OP_DIVU, 32'h00000064, 32'h0, "divu_zero");
        total++; if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin bad++; $display("FAIL divu_zero_const: got %h want 00000064ffffffff", {hi, lo}); end
        do_op(OP_DIV, 32'hFFFFFF9C, 32'h0, "div_zero_neg");
        do_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, "div_negdivisor");
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [63:0] exp;
        start = 1; op = OP_MULT; opA = 32'h00000007; opB = 32'hFFFFFFFD;
        sb.push_back(model(OP_MULT, 32'h00000007, 32'hFFFFFFFD));
        @(negedge clock);
        start = 0; cyc = 1;
        repeat (4) begin @(negedge clock); cyc++; end
        start = 1; op = OP_MTLO; opA = 32'hDEADBEEF;
        @(negedge clock);
        start = 0; cyc++;
        while (!done && cyc < 40) begin @(negedge clock); cyc++; end
        total++; if (cyc !== 34) begin bad++; $display("FAIL busy_ignore_done: got cycle %0d want 34", cyc); end
        exp = sb.pop_front();
        total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL busy_ignore_result: got %h want %h", {hi, lo}, exp); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        start = 1; op = OP_MULTU; opA = 32'h00001234; opB = 32'h00005678;
        @(negedge clock);
        start = 0;
        repeat (9) @(negedge clock);
        reset = 1; start = 1; op = OP_MTHI; opA = 32'h0000FFFF;
        @(negedge clock);
        reset = 0; start = 0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        seen = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1;
            @(negedge clock);
        end
        total++; if (seen) begin bad++; $display("FAIL midreset_quiet: got done/busy activity want none"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (i % 2 == 1) b = -b;
            do_op(o, a, b, $sformatf("random%0d", i));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_moves();
        test_reserved();
        test_vectors();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
